// File: rtl/cv_tmds_dec_if.sv
// TMDS decoder link bundle: deserializer word in, bitslip request back,
// lock status and registered decode results (de, ctl, dout) out.
// master = word source / result consumer, slave = decoder.
// Optional err_cnt member when TMDS_DEC_ERRCNT_EN is defined.
interface cv_tmds_dec_if;
    logic [9:0] din;
    logic       bitslip;
    logic       locked;
    logic       de;
    logic [1:0] ctl;
    logic [7:0] dout;
`ifdef TMDS_DEC_ERRCNT_EN
    logic [15:0] err_cnt;

    modport master (
        output din,
        input  bitslip, locked, de, ctl, dout, err_cnt
    );
    modport slave (
        input  din,
        output bitslip, locked, de, ctl, dout, err_cnt
    );
`else
    modport master (
        output din,
        input  bitslip, locked, de, ctl, dout
    );
    modport slave (
        input  din,
        output bitslip, locked, de, ctl, dout
    );
`endif
endinterface

// File: rtl/cv_tmds_dec.sv
// TMDS channel decoder with word-alignment FSM (SEARCH/SLIP/WAIT/LOCKED).
// Ports: clk, reset (async, active high), din[9:0] in; bitslip, locked,
// de, ctl[1:0], dout[7:0] out; err_cnt[15:0] out with TMDS_DEC_ERRCNT_EN.
// Parameters: LOCK_TOKENS, SEARCH_LEN, SLIP_WAIT.
module cv_tmds_dec_core #(
    parameter int LOCK_TOKENS = 16,
    parameter int SEARCH_LEN  = 4096,
    parameter int SLIP_WAIT   = 8
) (
    input  logic         clk,
    input  logic         reset,
    cv_tmds_dec_if.slave bus
);
    localparam int RW = $clog2(LOCK_TOKENS) + 1;
    localparam int TW = $clog2(SEARCH_LEN) + 1;
    localparam int WW = $clog2(SLIP_WAIT) + 1;

    localparam logic [RW-1:0] R_MAX  = RW'(LOCK_TOKENS);
    localparam logic [TW-1:0] T_LAST = TW'(SEARCH_LEN - 1);
    localparam logic [WW-1:0] W_LAST = WW'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] run_cnt, run_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          drop;

    logic          tok;
    logic [1:0]    tok_code;
    logic [7:0]    q;
    logic [7:0]    dec;

    logic          de_r;
    logic [1:0]    ctl_r;
    logic [7:0]    dout_r;

    // Control token recognition
    always_comb begin
        tok      = 1'b1;
        tok_code = 2'b00;
        case (bus.din)
            10'b1101010100: tok_code = 2'b00;
            10'b0010101011: tok_code = 2'b01;
            10'b0101010100: tok_code = 2'b10;
            10'b1010101011: tok_code = 2'b11;
            default:        tok      = 1'b0;
        endcase
    end

    // TMDS data decode: undo optional inversion, then undo XOR/XNOR chain
    always_comb begin
        q      = bus.din[9] ? ~bus.din[7:0] : bus.din[7:0];
        dec    = 8'h00;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = bus.din[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        timer_nxt = timer;
        wait_nxt  = wait_cnt;
        drop      = 1'b0;
        case (state)
            SEARCH: begin
                if (tok) begin
                    run_nxt = (run_cnt == R_MAX) ? run_cnt : run_cnt + 1'b1;
                end else begin
                    run_nxt = '0;
                end
                timer_nxt = timer + 1'b1;
                // Lock takes priority over a coincident timeout
                if (tok && run_nxt == R_MAX) begin
                    state_nxt = LOCKED;
                    timer_nxt = '0;
                end else if (timer == T_LAST) begin
                    state_nxt = SLIP;
                end
            end
            SLIP: begin
                state_nxt = WAIT;
                wait_nxt  = '0;
            end
            WAIT: begin
                if (wait_cnt == W_LAST) begin
                    state_nxt = SEARCH;
                    run_nxt   = '0;
                    timer_nxt = '0;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            LOCKED: begin
                if (tok) begin
                    timer_nxt = '0;
                end else if (timer == T_LAST) begin
                    // Lost alignment: re-search without slipping first
                    state_nxt = SEARCH;
                    run_nxt   = '0;
                    timer_nxt = '0;
                    drop      = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = SEARCH;
                run_nxt   = '0;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SEARCH;
            run_cnt  <= '0;
            timer    <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            run_cnt  <= run_nxt;
            timer    <= timer_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Outputs follow the lock status they are presented with
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_r   <= 1'b0;
            ctl_r  <= 2'b00;
            dout_r <= 8'h00;
        end else if (state_nxt == LOCKED) begin
            if (tok) begin
                de_r  <= 1'b0;
                ctl_r <= tok_code;
            end else begin
                de_r   <= 1'b1;
                dout_r <= dec;
            end
        end else begin
            de_r   <= 1'b0;
            ctl_r  <= 2'b00;
            dout_r <= 8'h00;
        end
    end

`ifdef TMDS_DEC_ERRCNT_EN
    logic [15:0] err_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 16'h0000;
        end else if (drop && err_r != 16'hFFFF) begin
            err_r <= err_r + 16'h0001;
        end
    end

    assign bus.err_cnt = err_r;
`endif

    assign bus.bitslip = (state == SLIP);
    assign bus.locked  = (state == LOCKED);
    assign bus.de      = de_r;
    assign bus.ctl     = ctl_r;
    assign bus.dout    = dout_r;
endmodule

module cv_tmds_dec #(
    parameter int LOCK_TOKENS = 16,
    parameter int SEARCH_LEN  = 4096,
    parameter int SLIP_WAIT   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  din,
    output logic        bitslip,
    output logic        locked,
    output logic        de,
    output logic [1:0]  ctl,
`ifdef TMDS_DEC_ERRCNT_EN
    output logic [15:0] err_cnt,
`endif
    output logic [7:0]  dout
);
    cv_tmds_dec_if bus ();

    assign bus.din = din;
    assign bitslip = bus.bitslip;
    assign locked  = bus.locked;
    assign de      = bus.de;
    assign ctl     = bus.ctl;
    assign dout    = bus.dout;
`ifdef TMDS_DEC_ERRCNT_EN
    assign err_cnt = bus.err_cnt;
`endif

    cv_tmds_dec_core #(
        .LOCK_TOKENS (LOCK_TOKENS),
        .SEARCH_LEN  (SEARCH_LEN),
        .SLIP_WAIT   (SLIP_WAIT)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );
endmodule

// File: tb/tb_cv_tmds_dec.sv
// Self-checking bench for cv_tmds_dec: reference model feeds a scoreboard
// queue, plus directed checks on lock timing, bitslip spacing and reset.
module tb_cv_tmds_dec;
    localparam int LT = 16;
    localparam int SL = 4096;
    localparam int SW = 8;

    localparam logic [9:0] T00 = 10'h354;
    localparam logic [9:0] T01 = 10'h0AB;
    localparam logic [9:0] T10 = 10'h154;
    localparam logic [9:0] T11 = 10'h2AB;
    localparam logic [9:0] D00 = 10'h200;

    logic clk = 1'b0;
    logic reset = 1'b1;

    cv_tmds_dec_if bus ();

    cv_tmds_dec #(
        .LOCK_TOKENS (LT),
        .SEARCH_LEN  (SL),
        .SLIP_WAIT   (SW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .din     (bus.din),
        .bitslip (bus.bitslip),
        .locked  (bus.locked),
        .de      (bus.de),
        .ctl     (bus.ctl),
`ifdef TMDS_DEC_ERRCNT_EN
        .err_cnt (bus.err_cnt),
`endif
        .dout    (bus.dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state: 0 search, 1 slip, 2 wait, 3 locked
    int         m_st, m_run, m_tmr, m_wt, m_err;
    logic       m_de;
    logic [1:0] m_ctl;
    logic [7:0] m_dout;

    logic [12:0] sb_q[$];
    int          ncyc;
    int          slips[$];

    task automatic model_reset();
        m_st = 0; m_run = 0; m_tmr = 0; m_wt = 0; m_err = 0;
        m_de = 1'b0; m_ctl = 2'b00; m_dout = 8'h00;
    endtask

    task automatic model_step(input logic [9:0] d);
        logic       tok;
        logic [1:0] code;
        logic [7:0] q, dd;
        int         nxt;
        tok = 1'b1;
        code = 2'b00;
        case (d)
            T00: code = 2'b00;
            T01: code = 2'b01;
            T10: code = 2'b10;
            T11: code = 2'b11;
            default: tok = 1'b0;
        endcase
        q = d[9] ? ~d[7:0] : d[7:0];
        dd[0] = q[0];
        for (int i = 1; i < 8; i++) dd[i] = q[i] ^ q[i-1] ^ ~d[8];
        nxt = m_st;
        case (m_st)
            0: begin
                m_run = tok ? ((m_run < LT) ? m_run + 1 : LT) : 0;
                if (tok && m_run == LT) begin
                    nxt = 3; m_tmr = 0;
                end else if (m_tmr == SL - 1) begin
                    nxt = 1;
                end else begin
                    m_tmr++;
                end
            end
            1: begin nxt = 2; m_wt = 0; end
            2: begin
                if (m_wt == SW - 1) begin
                    nxt = 0; m_run = 0; m_tmr = 0;
                end else begin
                    m_wt++;
                end
            end
            default: begin
                if (tok) begin
                    m_tmr = 0;
                end else if (m_tmr == SL - 1) begin
                    nxt = 0; m_run = 0; m_tmr = 0;
                    if (m_err < 65535) m_err++;
                end else begin
                    m_tmr++;
                end
            end
        endcase
        m_st = nxt;
        if (nxt == 3) begin
            if (tok) begin
                m_de = 1'b0; m_ctl = code;
            end else begin
                m_de = 1'b1; m_dout = dd;
            end
        end else begin
            m_de = 1'b0; m_ctl = 2'b00; m_dout = 8'h00;
        end
        sb_q.push_back({(nxt == 1), (nxt == 3), m_de, m_ctl, m_dout});
    endtask

    function automatic logic [12:0] outs();
        return {bus.bitslip, bus.locked, bus.de, bus.ctl, bus.dout};
    endfunction

    // Called just after a falling edge; returns just after the next one
    task automatic step(input logic [9:0] d);
        logic [12:0] e;
        bus.din = d;
        model_step(d);
        @(negedge clk);
        ncyc++;
        if (bus.bitslip) slips.push_back(ncyc);
        check("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_out", 32'(outs()), 32'(e));
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_async", 32'(outs()), 32'd0);
`ifdef TMDS_DEC_ERRCNT_EN
        check("rst_err", 32'(bus.err_cnt), 32'd0);
`endif
        sb_q.delete();
        model_reset();
        @(negedge clk);
        check("rst_hold", 32'(outs()), 32'd0);
        reset = 1'b0;
        ncyc = 0;
        slips.delete();
    endtask

    initial begin
        bus.din = 10'h000;
        @(negedge clk);
        do_reset();

        // Lock on 16 consecutive 0x354
        repeat (LT - 1) step(T00);
        check("lock_early", 32'(bus.locked), 32'd0);
        step(T00);
        check("lock_030", 32'(bus.locked), 32'd1);
        check("ctl_030", 32'(bus.ctl), 32'd0);
        check("de_030", 32'(bus.de), 32'd0);
        check("slips_030", 32'(slips.size()), 32'd0);

        // Control/data traffic while locked
        step(T11);
        check("ctl_11", 32'(bus.ctl), 32'd3);
        step(D00);
        check("de_032", 32'(bus.de), 32'd1);
        check("dout_032", 32'(bus.dout), 32'hFF);
        step(T10);
        check("de_tok", 32'(bus.de), 32'd0);
        check("ctl_10", 32'(bus.ctl), 32'd2);
        check("dout_hold", 32'(bus.dout), 32'hFF);
        for (int i = 0; i < 60; i++) step(10'($urandom));

        // Async reset while data is being presented
        step(D00);
        check("de_pre_rst", 32'(bus.de), 32'd1);
        do_reset();

        // Broken run does not lock; a full 0x0AB run does
        repeat (LT - 1) step(T00);
        step(D00);
        check("nolock_031", 32'(bus.locked), 32'd0);
        repeat (LT - 1) step(T01);
        check("lock_early_031", 32'(bus.locked), 32'd0);
        step(T01);
        check("lock_031", 32'(bus.locked), 32'd1);
        check("ctl_031", 32'(bus.ctl), 32'd1);

        // Loss of lock after SEARCH_LEN token-free cycles
        repeat (SL - 1) step(D00);
        check("still_locked", 32'(bus.locked), 32'd1);
        step(D00);
        check("unlock_034", 32'(bus.locked), 32'd0);
        check("slips_034", 32'(slips.size()), 32'd0);
`ifdef TMDS_DEC_ERRCNT_EN
        check("err_034", 32'(bus.err_cnt), 32'd1);
`endif

        // Bitslip cadence while searching
        do_reset();
        repeat (SL + SL + SW + 1 + 10) step(D00);
        check("slip_count", 32'(slips.size()), 32'd2);
        if (slips.size() >= 2) begin
            check("slip_first", 32'(slips[0]), 32'(SL));
            check("slip_gap", 32'(slips[1] - slips[0]), 32'(SL + SW + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cv_tmds_dec.md
CV_TMDS_DEC -- requirements
Module: cv_tmds_dec

Interface
REQ-001 SHALL have parameter LOCK_TOKENS, default 16: consecutive control tokens required to declare lock.
REQ-002 SHALL have parameter SEARCH_LEN, default 4096: cycles without a control token before slipping (search) or dropping lock (locked).
REQ-003 SHALL have parameter SLIP_WAIT, default 8: settle cycles after each bitslip pulse.
REQ-004 SHALL have port clk, input, 1: pixel-rate clock, the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port din, input, 10: parallel TMDS word from the deserializer, bit 0 first on the wire.
REQ-007 SHALL have port bitslip, output, 1: single-cycle pulse that requests a one-bit word-boundary shift from the deserializer.
REQ-008 SHALL have port locked, output, 1: word alignment achieved.
REQ-009 SHALL have port de, output, 1: dout holds a decoded video data word.
REQ-010 SHALL have port ctl, output, 2: last received control code {C1,C0}.
REQ-011 SHALL have port dout, output, 8: decoded data byte.

Function
REQ-012 SHALL map control tokens as follows: 10'b1101010100 to ctl=00; 10'b0010101011 to 01; 10'b0101010100 to 10; 10'b1010101011 to 11.
REQ-013 SHALL decode a non-token word as follows: q = din[9] ? ~din[7:0] : din[7:0]; d[0] = q[0]; for i = 1..7, d[i] = din[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
REQ-014 SHALL register de, ctl and dout once, so din sampled at cycle N appears on the outputs at cycle N+1.
REQ-015 SHALL, while locked: on a token, drive de=0, update ctl and hold dout; on a non-token, drive de=1 and dout=decoded byte, with ctl holding its last value.
REQ-016 SHALL, while not locked, drive de=0, ctl=00 and dout=0x00.
REQ-017 SHALL implement states SEARCH, SLIP, WAIT and LOCKED.
REQ-018 SHALL, in SEARCH, increment run_cnt on each token and clear it on each non-token, and increment timer every cycle.
REQ-019 SHALL transition SEARCH to LOCKED in the cycle where run_cnt reaches LOCK_TOKENS; locked=1 from the next cycle.
REQ-020 SHALL transition SEARCH to SLIP when timer reaches SEARCH_LEN-1 without lock; if lock and timeout occur in the same cycle, lock wins.
REQ-021 SHALL assert bitslip=1 for exactly one cycle in SLIP, then go to WAIT.
REQ-022 SHALL hold WAIT for SLIP_WAIT cycles, ignoring din, then go to SEARCH with run_cnt and timer cleared.
REQ-023 SHALL, in LOCKED, clear timer on each token; when timer reaches SEARCH_LEN-1 it goes to SEARCH, locked=0 from the next cycle, counters cleared, and no bitslip is issued on this transition.
REQ-024 SHALL saturate run_cnt at LOCK_TOKENS and size counters at clog2 of their parameter plus 1.
REQ-025 SHALL never assert bitslip outside the SLIP state, so bitslip pulses are at least SLIP_WAIT+1 cycles apart.

Reset
REQ-026 SHALL, on reset, immediately set state=SEARCH, run_cnt=0, timer=0, bitslip=0, locked=0, de=0, ctl=00 and dout=0x00.
REQ-027 SHALL, when reset is asserted mid-operation (any state), abort without emitting any further bitslip pulse, and restart in SEARCH when reset is released.

Configuration
REQ-028 SHALL, with TMDS_DEC_ERRCNT_EN defined, add output port err_cnt, 16 bits, reset 0x0000, which increments once per LOCKED-to-SEARCH transition and saturates at 0xFFFF.
REQ-029 SHALL, without TMDS_DEC_ERRCNT_EN, have no err_cnt port and no counter logic, with all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, then 16 consecutive din=0x354 -> locked=1 in the cycle after the 16th word, ctl=00, de=0, bitslip never asserted.
REQ-031 SHALL cover: 15 x 0x354, then 0x200, then 16 x 0x0AB -> no lock after the first run; lock after the 16th 0x0AB with ctl=01.
REQ-032 SHALL cover: locked, then din=0x200 -> one cycle later de=1, dout=0xFF; then din=0x154 -> de=0, ctl=10, dout holds 0xFF.
REQ-033 SHALL cover: SEARCH fed 4096 cycles of 0x200 -> one bitslip pulse at cycle 4096, none in the following 8 cycles, next pulse 4096+9 cycles later.
REQ-034 SHALL cover: locked, then 4096 cycles of 0x200 -> locked falls, bitslip stays 0, err_cnt=0x0001 (macro defined).
REQ-035 SHALL cover: reset asserted mid-LOCKED while de=1 -> locked, de, ctl and dout are all 0 in the same cycle, without waiting for a clock edge.
